// File: rtl/vga_timing_sequencer_if.sv
// Pixel-source and VGA pin bundle for vga_timing_sequencer.
// The master side is the sequencer, and the slave side is the colour source and connector.
interface vga_timing_sequencer_if;
    logic [2:0] iColor;
    logic [9:0] oCol;
    logic [9:0] oRow;
    logic       oVideoActive;
    logic       oFrameStart;
    logic       oPixelTick;
    logic       oVGA_R;
    logic       oVGA_G;
    logic       oVGA_B;
    logic       oHorizontal_Sync;
    logic       oVertical_Sync;

    modport master (
        input  iColor,
        output oCol, oRow, oVideoActive, oFrameStart, oPixelTick,
        output oVGA_R, oVGA_G, oVGA_B, oHorizontal_Sync, oVertical_Sync
    );

    modport slave (
        output iColor,
        input  oCol, oRow, oVideoActive, oFrameStart, oPixelTick,
        input  oVGA_R, oVGA_G, oVGA_B, oHorizontal_Sync, oVertical_Sync
    );
endinterface

// File: rtl/vga_timing_sequencer.sv
// VGA scan-out sequencer: pixel divider, H/V porch/sync FSMs and a one-tick colour/sync stage.
// Optional VGA_COLORBAR_EN replaces iColor with an eight-bar test pattern.
module vga_timing_sequencer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input logic                   Clock,
    input logic                   Reset,
    vga_timing_sequencer_if.master vga
);
    localparam int unsigned HTotal  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [3:0]  DivLast = 4'(CLK_DIV - 1);

    typedef enum logic [1:0] {HAct, HFp, HSync, HBp} h_state_e;
    typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_state_e;

    function automatic h_state_e h_decode(input logic [9:0] c);
        if (c < 10'(H_ACTIVE))                            return HAct;
        else if (c < 10'(H_ACTIVE + H_FRONT))             return HFp;
        else if (c < 10'(H_ACTIVE + H_FRONT + H_SYNC))    return HSync;
        else                                              return HBp;
    endfunction

    function automatic v_state_e v_decode(input logic [9:0] r);
        if (r < 10'(V_ACTIVE))                            return VAct;
        else if (r < 10'(V_ACTIVE + V_FRONT))             return VFp;
        else if (r < 10'(V_ACTIVE + V_FRONT + V_SYNC))    return VSync;
        else                                              return VBp;
    endfunction

    logic [3:0] div_q, div_d;
    logic       tick_q, tick_d;
    logic [9:0] col_q, col_d, row_q, row_d;
    h_state_e   h_state_q, h_state_d;
    v_state_e   v_state_q, v_state_d;
    logic       active_q, active_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [2:0] pix_color;

    always_comb begin
        div_d     = (div_q >= DivLast) ? 4'd0 : div_q + 4'd1;
        // Registered copy of "divider at CLK_DIV-1", so the strobe is low in reset.
        tick_d    = (div_d == DivLast);
        col_d     = col_q;
        row_d     = row_q;
        active_d  = active_q;
        rgb_d     = rgb_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        if (tick_q) begin
            if (col_q >= 10'(HTotal - 1)) begin
                col_d = '0;
                row_d = (row_q >= 10'(VTotal - 1)) ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
        h_state_d = h_decode(col_d);
        v_state_d = v_decode(row_d);
        if (tick_q) begin
            active_d = (h_state_d == HAct) && (v_state_d == VAct);
            rgb_d    = active_q ? pix_color : 3'b000;
            hsync_d  = (h_state_q != HSync);
            vsync_d  = (v_state_q != VSync);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            h_state_q <= HAct;
            v_state_q <= VAct;
            active_q  <= 1'b0;
            rgb_q     <= 3'b000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            col_q     <= col_d;
            row_q     <= row_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            active_q  <= active_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

`ifdef VGA_COLORBAR_EN
    localparam int unsigned BarWidth = H_ACTIVE / 8;

    logic [9:0] bar_px_q, bar_px_d;
    logic [2:0] bar_idx_q, bar_idx_d;

    // Bar position tracks col_q without a divide by BarWidth.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (tick_q) begin
            if (col_d == 10'd0) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q >= 10'(BarWidth - 1)) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + 10'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign pix_color = ~bar_idx_q;
`else
    assign pix_color = vga.iColor;
`endif

    assign vga.oCol             = col_q;
    assign vga.oRow             = row_q;
    assign vga.oVideoActive     = active_q;
    assign vga.oPixelTick       = tick_q;
    assign vga.oFrameStart      = tick_q && (col_q == 10'd0) && (row_q == 10'd0);
    assign vga.oVGA_R           = rgb_q[2];
    assign vga.oVGA_G           = rgb_q[1];
    assign vga.oVGA_B           = rgb_q[0];
    assign vga.oHorizontal_Sync = hsync_q;
    assign vga.oVertical_Sync   = vsync_q;
endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer on a shrunken 15x8 raster with CLK_DIV=2.
// Here n counts rising edges since reset release, and samples are taken on the falling edge after edge n.
module tb_vga_timing_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;
    int   max_row  = 0;
    logic [2:0] rgb;

    always #5 clk = ~clk;

    vga_timing_sequencer_if vif ();

    vga_timing_sequencer #(
        .CLK_DIV (2),
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .vga  (vif)
    );

    assign rgb = {vif.oVGA_R, vif.oVGA_G, vif.oVGA_B};

`ifdef VGA_COLORBAR_EN
    localparam logic [2:0] ExpC1 = 3'd6;
    localparam logic [2:0] ExpC7 = 3'd0;
    localparam logic [2:0] ExpP0 = 3'd7;
`else
    localparam logic [2:0] ExpC1 = 3'b101;
    localparam logic [2:0] ExpC7 = 3'b101;
    localparam logic [2:0] ExpP0 = 3'b101;
`endif

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
            if (int'(vif.oRow) > max_row) max_row = int'(vif.oRow);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_col"},  vif.oCol, 10'd0);
        chk({tag, "_row"},  vif.oRow, 10'd0);
        chk({tag, "_va"},   10'(vif.oVideoActive), 10'd0);
        chk({tag, "_fs"},   10'(vif.oFrameStart), 10'd0);
        chk({tag, "_tick"}, 10'(vif.oPixelTick), 10'd0);
        chk({tag, "_rgb"},  10'(rgb), 10'd0);
        chk({tag, "_hs"},   10'(vif.oHorizontal_Sync), 10'd1);
        chk({tag, "_vs"},   10'(vif.oVertical_Sync), 10'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        vif.iColor = 3'b101;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n     = 0;

        // Asynchronous reset asserted mid-line, between clock edges
        goto(9);
        chk("pre_col", vif.oCol, 10'd4);
        #2 rst_n = 1'b0;
        #1 chk_reset("t1");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n     = 0;

        goto(1);
        chk("first_tick", 10'(vif.oPixelTick), 10'd1);
        chk("first_fs", 10'(vif.oFrameStart), 10'd1);
        goto(2);
        chk("n2_tick", 10'(vif.oPixelTick), 10'd0);
        chk("n2_col", vif.oCol, 10'd1);
        chk("n2_va", 10'(vif.oVideoActive), 10'd1);
        chk("n2_rgb", 10'(rgb), 10'd0);
        goto(4);
        chk("col1_rgb", 10'(rgb), 10'(ExpC1));
        goto(16);
        chk("col8_va", 10'(vif.oVideoActive), 10'd0);
        chk("col7_rgb", 10'(rgb), 10'(ExpC7));
        goto(18);
        chk("col8_rgb", 10'(rgb), 10'd0);
        goto(21);
        chk("hs_before", 10'(vif.oHorizontal_Sync), 10'd1);
        goto(22);
        chk("hs_fall", 10'(vif.oHorizontal_Sync), 10'd0);
        goto(27);
        chk("hs_last_low", 10'(vif.oHorizontal_Sync), 10'd0);
        goto(28);
        chk("hs_rise", 10'(vif.oHorizontal_Sync), 10'd1);
        goto(29);
        chk("eol_col", vif.oCol, 10'd14);
        chk("eol_row", vif.oRow, 10'd0);
        goto(30);
        chk("wrap_col", vif.oCol, 10'd0);
        chk("wrap_row", vif.oRow, 10'd1);
        goto(120);
        chk("row4_va", 10'(vif.oVideoActive), 10'd0);
        goto(122);
        chk("row4_rgb", 10'(rgb), 10'd0);
        goto(151);
        chk("vs_before", 10'(vif.oVertical_Sync), 10'd1);
        goto(152);
        chk("vs_fall", 10'(vif.oVertical_Sync), 10'd0);
        goto(211);
        chk("vs_last_low", 10'(vif.oVertical_Sync), 10'd0);
        goto(212);
        chk("vs_rise", 10'(vif.oVertical_Sync), 10'd1);
        goto(239);
        chk("fs_not_yet", 10'(vif.oFrameStart), 10'd0);
        goto(240);
        chk("frame_wrap_row", vif.oRow, 10'd0);
        goto(241);
        chk("fs_period", 10'(vif.oFrameStart), 10'd1);
        goto(242);
        chk("frame2_p0_rgb", 10'(rgb), 10'(ExpP0));

        // One-clock reset pulse at (col 12, row 6), inside vertical sync
        goto(444);
        chk("pre_pulse_row", vif.oRow, 10'd6);
        rst_n = 1'b0;
        #1 chk_reset("t6");
        @(negedge clk);
        rst_n = 1'b1;
        n     = 0;
        goto(1);
        chk("t6_first_fs", 10'(vif.oFrameStart), 10'd1);
        goto(151);
        chk("t6_vs_before", 10'(vif.oVertical_Sync), 10'd1);
        goto(152);
        chk("t6_vs_fall", 10'(vif.oVertical_Sync), 10'd0);
        goto(239);
        chk("t6_fs_not_yet", 10'(vif.oFrameStart), 10'd0);
        goto(241);
        chk("t6_fs_period", 10'(vif.oFrameStart), 10'd1);
        chk("max_row", 10'(max_row), 10'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
